// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: after the last active row ends, runs the paddle,
// ball and score update tasks in order during vertical blanking.
// Define UPDATE_TIMEOUT_EN to add a per-task watchdog that advances past a
// silent task and records it in o_timeout.
module frame_update_scheduler #(
  parameter logic [8:0] LAST_ROW = 9'd271,
  parameter logic [9:0] TIMEOUT  = 10'd1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_data_enable,
  input  logic [8:0]  i_row,
  input  logic [2:0]  i_ack,
  input  logic        i_clr_flags,
  output logic [2:0]  o_req,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_overrun,
  output logic [2:0]  o_timeout
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WD_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TASK = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic               de_q, de_d;
  logic [2:0]         req_q, req_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;

  logic               eof_c;
  logic               ack_c;
  logic               adv_c;

`ifdef UPDATE_TIMEOUT_EN
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [2:0]         timeout_q, timeout_d;
  logic               expire_c;
`endif

  // End of frame: active video just dropped on the final active row
  assign eof_c = de_q & ~i_data_enable & (i_row == LAST_ROW);
  // Only the acknowledge of the task currently requested counts
  assign ack_c = i_ack[idx_q];

`ifdef UPDATE_TIMEOUT_EN
  // Watchdog expiry only counts when the task did not ack in the same cycle
  assign expire_c = (wd_q == TIMEOUT) & ~ack_c;
  assign adv_c    = ack_c | expire_c;
`else
  assign adv_c    = ack_c;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    de_d         = i_data_enable;
    req_d        = req_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = i_clr_flags ? 1'b0 : overrun_q;
`ifdef UPDATE_TIMEOUT_EN
    wd_d         = wd_q;
    timeout_d    = i_clr_flags ? 3'b000 : timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (eof_c) begin
          state_d = TASK;
          idx_d   = 2'd0;
          req_d   = 3'b001;
`ifdef UPDATE_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      TASK: begin
        if (i_data_enable) begin
          // Active video returned before the sequence finished
          state_d   = IDLE;
          idx_d     = 2'd0;
          req_d     = 3'b000;
          overrun_d = 1'b1;
        end else if (adv_c) begin
`ifdef UPDATE_TIMEOUT_EN
          if (expire_c) begin
            timeout_d[idx_q] = 1'b1;
          end
          wd_d = '0;
`endif
          if (idx_q == 2'd2) begin
            state_d      = DONE;
            idx_d        = 2'd0;
            req_d        = 3'b000;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + 2'd1;
            req_d = 3'(3'b001 << (idx_q + 2'd1));
          end
        end else begin
`ifdef UPDATE_TIMEOUT_EN
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        req_d   = 3'b000;
      end
    endcase

    busy_d = (state_d == TASK);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      de_q         <= 1'b0;
      req_q        <= 3'b000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      de_q         <= de_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef UPDATE_TIMEOUT_EN
  // Watchdog counter and sticky timeout flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 3'b000;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign o_timeout      = 3'b000;
`endif

  assign o_req        = req_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler with a request/count scoreboard.
module tb_frame_update_scheduler;

  localparam logic [9:0] TMO = 10'd8;
`ifdef UPDATE_TIMEOUT_EN
  localparam int D2 = 8;
`else
  localparam int D2 = 9;
`endif

  logic        i_clk;
  logic        i_rst;
  logic        i_data_enable;
  logic [8:0]  i_row;
  logic [2:0]  i_ack;
  logic        i_clr_flags;
  logic [2:0]  o_req;
  logic        o_busy;
  logic        o_frame_done;
  logic [15:0] o_frame_cnt;
  logic        o_overrun;
  logic [2:0]  o_timeout;

  frame_update_scheduler #(
    .LAST_ROW (9'd271),
    .TIMEOUT  (TMO)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data_enable (i_data_enable),
    .i_row         (i_row),
    .i_ack         (i_ack),
    .i_clr_flags   (i_clr_flags),
    .o_req         (o_req),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_frame_cnt   (o_frame_cnt),
    .o_overrun     (o_overrun),
    .o_timeout     (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0]  exp_req_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [15:0] cnt_model = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Active video ends on the given row
  task automatic eof_at(input logic [8:0] row);
    i_row = row;
    i_data_enable = 1'b1;
    cyc();
    i_data_enable = 1'b0;
    cyc();
    i_row = 9'd0;
  endtask

  task automatic start_frame();
    exp_req_q.push_back(3'b001);
    exp_req_q.push_back(3'b010);
    exp_req_q.push_back(3'b100);
    exp_cnt_q.push_back(cnt_model + 16'd1);
    eof_at(9'd271);
  endtask

  task automatic next_req(input string tag);
    logic [2:0] e;
    if (exp_req_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed req %0h expected none queued", tag, o_req);
    end else begin
      e = exp_req_q.pop_front();
      chk(tag, 32'(o_req), 32'(e));
    end
  endtask

  // Serve task k: other ack bits high for dly cycles, then the real ack
  task automatic serve(input int k, input int dly);
    logic [2:0] oh;
    int held;
    oh = 3'(1 << k);
    held = 0;
    next_req($sformatf("req_task%0d", k));
    chk($sformatf("busy_task%0d", k), 32'(o_busy), 32'd1);
    for (int i = 0; i < dly; i++) begin
      i_ack = ~oh;
      cyc();
      if (o_req === oh) held++;
    end
    chk($sformatf("hold_task%0d", k), 32'(held), 32'(dly));
    i_ack = oh;
    cyc();
    i_ack = 3'b000;
  endtask

  task automatic frame_end(input string tag);
    logic [15:0] e;
    chk({tag, "_done"}, 32'(o_frame_done), 32'd1);
    chk({tag, "_req0"}, 32'(o_req), 32'd0);
    chk({tag, "_busy0"}, 32'(o_busy), 32'd0);
    if (exp_cnt_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_cnt: observed %0h expected none queued", tag, o_frame_cnt);
    end else begin
      e = exp_cnt_q.pop_front();
      chk({tag, "_cnt"}, 32'(o_frame_cnt), 32'(e));
      cnt_model = e;
    end
    cyc();
    chk({tag, "_done_single"}, 32'(o_frame_done), 32'd0);
  endtask

  initial begin
    int pulses;
    int stay;
    i_rst = 1'b1;
    i_data_enable = 1'b0;
    i_row = 9'd0;
    i_ack = 3'b000;
    i_clr_flags = 1'b0;
    #1;
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    chk("rst_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_flags", 32'({o_overrun, o_timeout}), 32'd0);
    cyc();
    cyc();
    i_rst = 1'b0;
    cyc();

    // Video ends on a non-final row; acks in idle are ignored
    eof_at(9'd100);
    pulses = 0;
    i_ack = 3'b111;
    for (int i = 0; i < 4; i++) begin
      if (o_req !== 3'b000 || o_busy !== 1'b0) pulses++;
      cyc();
    end
    i_ack = 3'b000;
    chk("row100_idle", 32'(pulses), 32'd0);

    // Normal frame
    start_frame();
    serve(0, 5);
    serve(1, 7);
    serve(2, D2);
    frame_end("frame1");

    // Task 1 silent, active video returns
    start_frame();
    serve(0, 2);
    next_req("ovr_req1");
    i_ack = 3'b101;
    cyc();
    cyc();
    cyc();
    i_ack = 3'b000;
    i_row = 9'd0;
    i_data_enable = 1'b1;
    cyc();
    exp_req_q.delete();
    exp_cnt_q.delete();
    chk("ovr_req0", 32'(o_req), 32'd0);
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    chk("ovr_busy0", 32'(o_busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_frame_done !== 1'b0) pulses++;
      cyc();
    end
    i_data_enable = 1'b0;
    chk("ovr_no_done", 32'(pulses), 32'd0);
    chk("ovr_cnt", 32'(o_frame_cnt), 32'(cnt_model));
    i_clr_flags = 1'b1;
    cyc();
    i_clr_flags = 1'b0;
    chk("clr_overrun", 32'(o_overrun), 32'd0);

    // Abort beats ack[2]; overrun set beats a same-cycle clear
    start_frame();
    serve(0, 1);
    serve(1, 1);
    next_req("prio_req2");
    i_ack = 3'b100;
    i_data_enable = 1'b1;
    i_clr_flags = 1'b1;
    cyc();
    i_ack = 3'b000;
    i_clr_flags = 1'b0;
    exp_req_q.delete();
    exp_cnt_q.delete();
    chk("prio_req0", 32'(o_req), 32'd0);
    chk("prio_overrun", 32'(o_overrun), 32'd1);
    chk("prio_no_done", 32'(o_frame_done), 32'd0);
    chk("prio_cnt", 32'(o_frame_cnt), 32'(cnt_model));
    i_data_enable = 1'b0;
    cyc();

    // Watchdog behaviour
`ifdef UPDATE_TIMEOUT_EN
    start_frame();
    next_req("tmo_req0");
    stay = 0;
    for (int i = 0; i < 40 && o_req === 3'b001; i++) begin
      stay++;
      cyc();
    end
    chk("tmo_stay", 32'(stay), 32'(TMO) + 32'd1);
    chk("tmo_flag", 32'(o_timeout), 32'd1);
    serve(1, int'(TMO));
    chk("tmo_ack_wins", 32'(o_timeout), 32'd1);
    serve(2, 2);
    frame_end("tmo_frame");
    i_clr_flags = 1'b1;
    cyc();
    i_clr_flags = 1'b0;
    chk("clr_timeout", 32'(o_timeout), 32'd0);
`else
    start_frame();
    next_req("wait_req0");
    stay = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (o_req === 3'b001) stay++;
    end
    chk("wait_indef", 32'(stay), 32'd20);
    chk("no_timeout", 32'(o_timeout), 32'd0);
    i_ack = 3'b001;
    cyc();
    i_ack = 3'b000;
    serve(1, 1);
    serve(2, 1);
    frame_end("wait_frame");
`endif

    // Reset between clock edges in the middle of a sequence
    start_frame();
    serve(0, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_req", 32'(o_req), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_cnt", 32'(o_frame_cnt), 32'd0);
    chk("arst_overrun", 32'(o_overrun), 32'd0);
    exp_req_q.delete();
    exp_cnt_q.delete();
    cnt_model = 16'd0;
    cyc();
    i_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (o_req !== 3'b000) pulses++;
    end
    chk("arst_waits", 32'(pulses), 32'd0);
    start_frame();
    serve(0, 1);
    serve(1, 2);
    serve(2, 3);
    frame_end("after_rst");

    // Counter at its last value, one more frame wraps it
    force dut.frame_cnt_d = 16'hFFFF;
    cyc();
    release dut.frame_cnt_d;
    cnt_model = 16'hFFFF;
    chk("preload_cnt", 32'(o_frame_cnt), 32'h0000FFFF);
    start_frame();
    serve(0, 1);
    serve(1, 1);
    serve(2, 1);
    frame_end("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
